mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port memory arbiter and bus sequencer between the CPU control unit and a second bus master (DMA/loader) sharing the single memory port. Accepts one read or write at a time, grants round-robin, drives the memory strobes, address and write data from registers, waits for the memory acknowledge, and returns read data with a one-cycle completion pulse. Requester 0 is the CPU's `mem_rd`/`mem_wr` path; requester 1 is the auxiliary master.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `TIMEOUT`, 16: max cycles in ACCESS before abort; 0 disables timeout.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req0`, `req1` in 1 each: access request; held high with its attributes until `done`/`err` of that port.
- `we0`, `we1` in 1 each: 1 = write, 0 = read.
- `addr0`, `addr1` in ADDR_W each: access address.
- `wdata0`, `wdata1` in DATA_W each: write data.
- `gnt0`, `gnt1` out 1 each: high from grant until completion cycle inclusive.
- `done0`, `done1` out 1 each: one-cycle completion pulse.
- `err0`, `err1` out 1 each: one-cycle timeout pulse, replaces `done`.
- `rdata` out DATA_W: read data register, shared, valid when `doneN` is high after a read.
- `mem_rd`, `mem_wr` out 1 each: memory strobes, registered.
- `mem_addr` out ADDR_W, `mem_wdata` out DATA_W: registered address and data.
- `mem_rdata` in DATA_W: memory read data, sampled on `mem_ack`.
- `mem_ack` in 1: memory completion, level, sampled in ACCESS only.

## Operation
- States: IDLE, ACCESS, DONE. Reset to IDLE.
- IDLE: no request → stay. Any request → grant, latch `we`/`addr`/`wdata` of winner into `mem_*`, set strobe (`mem_wr` if we else `mem_rd`), clear timeout counter, go ACCESS.
- Arbitration: round-robin on register `last` (reset 1, so port 0 wins first simultaneous request). Single requester wins regardless of `last`. Both requesting → port ≠ `last`. `last` updated to winner at grant.
- ACCESS: `mem_ack`=1 → drop strobes, on read capture `mem_rdata` into `rdata` (writes leave `rdata` unchanged), go DONE with status ok. Else counter increments; counter reaches TIMEOUT-1 without ack (TIMEOUT≠0) → drop strobes, go DONE with status err, `rdata` unchanged.
- DONE: pulse `doneN` (or `errN`) for granted port, `gntN` still high; next edge → IDLE, `gnt` low, `mem_addr`/`mem_wdata` hold last values.
- Request input changes or withdrawals during ACCESS/DONE ignored; latched access completes.
- `mem_ack` in IDLE or DONE ignored.
- `gnt0` and `gnt1` never high together; `mem_rd` and `mem_wr` never high together.

## Timing
- Reset values: all `gnt`/`done`/`err` 0, `mem_rd`=`mem_wr`=0, `mem_addr`=0, `mem_wdata`=0, `rdata`=0, state IDLE, `last`=1, counter 0. Reset asserted mid-access clears immediately (async); no done/err for the aborted access.
- Request high at edge E in IDLE → `gnt`, strobe, `mem_addr` valid after E.
- `mem_ack` sampled at edge E+k (k≥1) → strobes low and `done`/`rdata` valid after E+k for one cycle; `gnt` low after E+k+1.
- Minimum access: 3 cycles from grant edge to return to IDLE (ack in first ACCESS cycle). Memory may hold `mem_ack` high continuously; each access still costs 3 cycles.
- Timeout: with no ack, strobes drop after edge E+TIMEOUT; `err` high for the following cycle.
- Port still requesting in the IDLE cycle after its DONE is a new request; with other port waiting, round-robin gives the other port the next grant.

## Test plan
- Reset then `req0`=1, we0=0, addr0=0x40, memory acks 2 cycles later with 0xDEADBEEF → `gnt0` one cycle after req, `mem_rd`=1 with `mem_addr`=0x40 for 2 cycles, `done0` one cycle with `rdata`=0xDEADBEEF, `gnt1` stays 0.
- `req1` write addr 0x10 data 0x1234 with immediate ack → `mem_wr`=1, `mem_wdata`=0x1234 exactly one cycle, `done1` pulse, `rdata` unchanged; total 3 cycles grant-to-IDLE.
- Both requests held from reset, ack always 1 → grants alternate 0,1,0,1 every 3 cycles; never both `gnt` high.
- TIMEOUT=4, `req0` read, `mem_ack` tied 0 → `mem_rd` high 4 cycles, `err0` one cycle, no `done0`, `rdata` unchanged; then ack-ed request proceeds normally.
- `rst_n` low during ACCESS → strobes, `gnt`, counter cleared immediately; after release, pending `req1` with `req0` also high → port 0 granted first.
- `req0` dropped and `addr0` changed mid-ACCESS, stray `mem_ack` pulses in IDLE → original address held on `mem_addr`, access completes with `done0`, stray acks produce no `done`.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port round-robin memory arbiter and bus sequencer (IDLE -> ACCESS -> DONE).
// Memory strobes, address and write data are driven from registers; access timeout is optional.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state, state_n;
    logic              last, last_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic              gnt0_n, gnt1_n;
    logic              done0_n, done1_n;
    logic              err0_n, err1_n;
    logic [DATA_W-1:0] rdata_n;
    logic              mem_rd_n, mem_wr_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [DATA_W-1:0] mem_wdata_n;
    logic              win1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= 1'b1;
            cnt       <= '0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            err0      <= 1'b0;
            err1      <= 1'b0;
            rdata     <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_n;
            last      <= last_n;
            cnt       <= cnt_n;
            gnt0      <= gnt0_n;
            gnt1      <= gnt1_n;
            done0     <= done0_n;
            done1     <= done1_n;
            err0      <= err0_n;
            err1      <= err1_n;
            rdata     <= rdata_n;
            mem_rd    <= mem_rd_n;
            mem_wr    <= mem_wr_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
        end
    end

    // Port 1 wins when alone, or when both request and port 0 won last time.
    assign win1 = req1 && (!req0 || !last);

    always_comb begin
        state_n     = state;
        last_n      = last;
        cnt_n       = cnt;
        gnt0_n      = gnt0;
        gnt1_n      = gnt1;
        done0_n     = 1'b0;
        done1_n     = 1'b0;
        err0_n      = 1'b0;
        err1_n      = 1'b0;
        rdata_n     = rdata;
        mem_rd_n    = mem_rd;
        mem_wr_n    = mem_wr;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;

        unique case (state)
            IDLE: begin
                if (req0 || req1) begin
                    gnt0_n      = !win1;
                    gnt1_n      = win1;
                    last_n      = win1;
                    mem_addr_n  = win1 ? addr1 : addr0;
                    mem_wdata_n = win1 ? wdata1 : wdata0;
                    mem_wr_n    = win1 ? we1 : we0;
                    mem_rd_n    = win1 ? !we1 : !we0;
                    cnt_n       = '0;
                    state_n     = ACCESS;
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    if (mem_rd) begin
                        rdata_n = mem_rdata;
                    end
                    mem_rd_n = 1'b0;
                    mem_wr_n = 1'b0;
                    done0_n  = gnt0;
                    done1_n  = gnt1;
                    state_n  = DONE;
                end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
                    mem_rd_n = 1'b0;
                    mem_wr_n = 1'b0;
                    err0_n   = gnt0;
                    err1_n   = gnt1;
                    state_n  = DONE;
                end else if (TIMEOUT != 0) begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DONE: begin
                gnt0_n  = 1'b0;
                gnt1_n  = 1'b0;
                state_n = IDLE;
            end
            default: begin
                gnt0_n   = 1'b0;
                gnt1_n   = 1'b0;
                mem_rd_n = 1'b0;
                mem_wr_n = 1'b0;
                state_n  = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter (TIMEOUT = 4) with hand-written
// sequences for round-robin under reset, request withdrawal and stray acks.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, done0, done1, err0, err1;
    logic [31:0] rdata;
    logic        mem_rd, mem_wr;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .err0(err0), .err1(err1), .rdata(rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrdata;
        int          ack_k;     // edge after grant where ack is sampled; 0 = never
        bit          exp_err;
        int          exp_k;     // edge after grant where done/err appears
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int k;
        int strobes;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = v.mrdata;
        if (v.port) begin
            req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata;
        end else begin
            req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata;
        end
        @(posedge clk); #1;
        check("grant", v.port ? gnt1 : gnt0, 1);
        check("other_gnt", v.port ? gnt0 : gnt1, 0);
        check("strobe_kind", {mem_wr, mem_rd}, v.we ? 2'b10 : 2'b01);
        check("mem_addr", mem_addr, v.addr);
        if (v.we) check("mem_wdata", mem_wdata, v.wdata);
        strobes = (mem_rd || mem_wr) ? 1 : 0;
        k = 0;
        while (!(done0 || done1 || err0 || err1) && k < 20) begin
            k++;
            @(negedge clk);
            mem_ack = (k == v.ack_k);
            @(posedge clk); #1;
            if (mem_rd || mem_wr) strobes++;
            if (!(done0 || done1 || err0 || err1)) check("addr_hold", mem_addr, v.addr);
        end
        check("end_edge", k, v.exp_k);
        check("strobe_cycles", strobes, v.exp_k);
        check("done", v.port ? done1 : done0, !v.exp_err);
        check("err", v.port ? err1 : err0, v.exp_err);
        check("other_pulse", v.port ? (done0 | err0) : (done1 | err1), 0);
        check("gnt_in_done", v.port ? gnt1 : gnt0, 1);
        check("rdata", rdata, v.exp_rdata);
        @(negedge clk);
        mem_ack = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        @(posedge clk); #1;
        check("gnt_release", {gnt0, gnt1}, 2'b00);
        check("pulse_end", {done0, done1, err0, err1}, 4'b0000);
    endtask

    initial begin
        vecs[0] = '{0, 0, 32'h40,       32'h0,       32'hDEADBEEF, 2, 0, 2, 32'hDEADBEEF};
        vecs[1] = '{1, 1, 32'h10,       32'h1234,    32'h11111111, 1, 0, 1, 32'hDEADBEEF};
        vecs[2] = '{0, 0, 32'h80,       32'h0,       32'h22222222, 0, 1, 4, 32'hDEADBEEF};
        vecs[3] = '{1, 0, 32'h24,       32'h0,       32'hCAFEF00D, 4, 0, 4, 32'hCAFEF00D};
        vecs[4] = '{0, 1, 32'h12345678, 32'hA5A5A5A5, 32'h33333333, 3, 0, 3, 32'hCAFEF00D};
        vecs[5] = '{1, 0, 32'h8,        32'h0,       32'h00000000, 1, 0, 1, 32'h00000000};

        rst_n = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        mem_rdata = '0; mem_ack = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", {gnt0, gnt1}, 2'b00);
        check("rst_pulses", {done0, done1, err0, err1}, 4'b0000);
        check("rst_strobes", {mem_rd, mem_wr}, 2'b00);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_rdata", rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Stray acks in IDLE, then request withdrawn and address changed mid-access.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); mem_ack = 1'b1;
            @(posedge clk); #1;
            check("stray_ack_idle", {gnt0, gnt1, done0, done1}, 4'b0000);
        end
        @(negedge clk);
        mem_ack = 1'b0; req0 = 1'b1; we0 = 1'b0; addr0 = 32'h100; mem_rdata = 32'h5555AAAA;
        @(posedge clk); #1;
        check("wd_grant", gnt0, 1);
        check("wd_addr0", mem_addr, 32'h100);
        @(negedge clk);
        req0 = 1'b0; addr0 = 32'h999;
        @(posedge clk); #1;
        check("wd_addr1", mem_addr, 32'h100);
        check("wd_rd_held", {gnt0, mem_rd}, 2'b11);
        @(posedge clk); #1;
        check("wd_addr2", mem_addr, 32'h100);
        @(negedge clk); mem_ack = 1'b1;
        @(posedge clk); #1;
        check("wd_done", done0, 1);
        check("wd_rdata", rdata, 32'h5555AAAA);
        @(posedge clk); #1;
        check("wd_idle", {gnt0, done0, mem_rd}, 3'b000);
        check("wd_addr_kept", mem_addr, 32'h100);
        @(posedge clk); #1;
        check("wd_no_extra_done", {gnt0, gnt1, done0, done1}, 4'b0000);
        @(negedge clk); mem_ack = 1'b0;

        // Async reset mid-access, then both ports held with ack always high.
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h200;
        @(posedge clk); #1;
        check("ra_grant", gnt0, 1);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("ra_cleared", {gnt0, gnt1, mem_rd, mem_wr}, 4'b0000);
        check("ra_addr", mem_addr, 0);
        check("ra_no_pulse", {done0, err0}, 2'b00);
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h300; wdata1 = 32'h77; mem_ack = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            logic [3:0] exp;
            @(posedge clk); #1;
            case (i % 6)
                0: exp = 4'b1000;
                1: exp = 4'b1010;
                3: exp = 4'b0100;
                4: exp = 4'b0101;
                default: exp = 4'b0000;
            endcase
            check("rr_gnt_done", {gnt0, gnt1, done0, done1}, exp);
            check("rr_exclusive", (gnt0 & gnt1) | (mem_rd & mem_wr), 0);
        end
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0; mem_ack = 1'b0;
        repeat (4) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
